// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: RAW-hazard stalls, branch redirect flushes, stall watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        suspend_i,
  input  logic        branch_taken_i,
  output logic        pc_we_o,
  output logic        if_id_we_o,
  output logic        if_id_flush_o,
  output logic        id_exe_flush_o,
  output logic        stall_active_o,
  output logic        stall_err_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [3:0] MAX_STALL_C  = 4'(MAX_STALL);
  localparam logic [3:0] STALL_SAT_C  = 4'd15;
  localparam logic [2:0] FLUSH_LOAD_C = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH_C = (FLUSH_CYCLES > 1);

  state_t      state_q, state_d;
  logic [3:0]  stall_cnt_q, stall_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        stall_err_q, stall_err_d;

  logic        pc_we_s;
  logic        if_id_we_s;
  logic        if_id_flush_s;
  logic        id_exe_flush_s;
  logic        stall_active_s;

  // Next-state and control decode; a taken branch always wins because the ID instruction is wrong-path.
  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    stall_err_d    = stall_err_q;
    pc_we_s        = 1'b1;
    if_id_we_s     = 1'b1;
    if_id_flush_s  = 1'b0;
    id_exe_flush_s = 1'b0;
    stall_active_s = 1'b0;

    if (branch_taken_i) begin
      if_id_flush_s  = 1'b1;
      id_exe_flush_s = 1'b1;
      stall_cnt_d    = 4'd0;
      if (MULTI_FLUSH_C) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_LOAD_C;
      end else begin
        state_d     = ST_RUN;
        flush_cnt_d = 3'd0;
      end
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (suspend_i) begin
            pc_we_s        = 1'b0;
            if_id_we_s     = 1'b0;
            id_exe_flush_s = 1'b1;
            stall_active_s = 1'b1;
            state_d        = ST_STALL;
            if (stall_cnt_q == STALL_SAT_C) begin
              stall_cnt_d = STALL_SAT_C;
            end else begin
              stall_cnt_d = stall_cnt_q + 4'd1;
            end
            // Watchdog trips on the cycle after MAX_STALL consecutive stalls and stays set.
            if (stall_cnt_q == MAX_STALL_C) begin
              stall_err_d = 1'b1;
            end else begin
              stall_err_d = stall_err_q;
            end
          end else begin
            state_d     = ST_RUN;
            stall_cnt_d = 4'd0;
          end
        end
        ST_FLUSH: begin
          if_id_flush_s  = 1'b1;
          id_exe_flush_s = 1'b1;
          stall_cnt_d    = 4'd0;
          if (flush_cnt_q <= 3'd1) begin
            state_d     = ST_RUN;
            flush_cnt_d = 3'd0;
          end else begin
            state_d     = ST_FLUSH;
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d     = ST_RUN;
          stall_cnt_d = 4'd0;
          flush_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // Output drive; while reset is held the pipeline is frozen and filled with bubbles.
  always_comb begin
    if (!rst_i) begin
      pc_we_o        = 1'b0;
      if_id_we_o     = 1'b0;
      if_id_flush_o  = 1'b1;
      id_exe_flush_o = 1'b1;
      stall_active_o = 1'b0;
    end else begin
      pc_we_o        = pc_we_s;
      if_id_we_o     = if_id_we_s;
      if_id_flush_o  = if_id_flush_s;
      id_exe_flush_o = id_exe_flush_s;
      stall_active_o = stall_active_s;
    end
  end

  assign stall_err_o = stall_err_q;

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 4'd0;
      flush_cnt_q <= 3'd0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Event counters wrap naturally at 2^32.
  always_comb begin
    if (stall_active_s) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (branch_taken_i) begin
      flush_events_d = flush_events_q + 32'd1;
    end else begin
      flush_events_d = flush_events_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default instance plus a FLUSH_CYCLES=3 instance.
module tb_pipeline_stall_ctrl;

  logic clk;
  logic rst_i;
  logic sus1, br1, sus2, br2;
  logic pc_we1, ifid_we1, ifid_fl1, idex_fl1, stall_act1, err1;
  logic pc_we2, ifid_we2, ifid_fl2, idex_fl2, stall_act2, err2;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cyc1, flush_ev1, stall_cyc2, flush_ev2;
`endif
  logic [5:0] o1, o2;

  int n_checks;
  int n_fail;

  // {pc_we, if_id_we, if_id_flush, id_exe_flush, stall_active, stall_err}
  localparam logic [5:0] O_RST   = 6'b001100;
  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b000110;
  localparam logic [5:0] O_FLUSH = 6'b111100;

  assign o1 = {pc_we1, ifid_we1, ifid_fl1, idex_fl1, stall_act1, err1};
  assign o2 = {pc_we2, ifid_we2, ifid_fl2, idex_fl2, stall_act2, err2};

  pipeline_stall_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .suspend_i(sus1), .branch_taken_i(br1),
    .pc_we_o(pc_we1), .if_id_we_o(ifid_we1), .if_id_flush_o(ifid_fl1),
    .id_exe_flush_o(idex_fl1), .stall_active_o(stall_act1), .stall_err_o(err1)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles_o(stall_cyc1), .flush_events_o(flush_ev1)
`endif
  );

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(3)) dut3 (
    .clk_i(clk), .rst_i(rst_i), .suspend_i(sus2), .branch_taken_i(br2),
    .pc_we_o(pc_we2), .if_id_we_o(ifid_we2), .if_id_flush_o(ifid_fl2),
    .id_exe_flush_o(idex_fl2), .stall_active_o(stall_act2), .stall_err_o(err2)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cycles_o(stall_cyc2), .flush_events_o(flush_ev2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    rst_i = 1'b0; sus1 = 1'b0; br1 = 1'b0; sus2 = 1'b0; br2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o1 !== O_RST) begin
        n_fail++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, o1, O_RST);
      end
      @(negedge clk);
    end
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (o1 !== O_RUN || o2 !== O_RUN) begin
        n_fail++; $display("FAIL reset_idle cyc%0d: got %b/%b want %b", i, o1, o2, O_RUN);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall3;
    for (int i = 0; i < 3; i++) begin
      sus1 = 1'b1; #1;
      n_checks++;
      if (o1 !== O_STALL) begin
        n_fail++; $display("FAIL stall3 cyc%0d: got %b want %b", i, o1, O_STALL);
      end
      @(negedge clk);
    end
    sus1 = 1'b0; #1;
    n_checks++;
    if (o1 !== O_RUN) begin
      n_fail++; $display("FAIL stall3_release: got %b want %b", o1, O_RUN);
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog;
    for (int i = 0; i < 4; i++) begin
      sus1 = 1'b1; #1;
      n_checks++;
      if (o1 !== O_STALL) begin
        n_fail++; $display("FAIL wdog_stall cyc%0d: got %b want %b", i, o1, O_STALL);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      sus1 = 1'b0; #1;
      n_checks++;
      if (o1 !== (O_RUN | 6'b000001)) begin
        n_fail++; $display("FAIL wdog_sticky cyc%0d: got %b want %b", i, o1, O_RUN | 6'b000001);
      end
      @(negedge clk);
    end
    rst_i = 1'b0; #1;
    n_checks++;
    if (o1 !== O_RST) begin
      n_fail++; $display("FAIL wdog_reset_clear: got %b want %b", o1, O_RST);
    end
    @(negedge clk);
    rst_i = 1'b1; #1;
    n_checks++;
    if (o1 !== O_RUN) begin
      n_fail++; $display("FAIL wdog_after_reset: got %b want %b", o1, O_RUN);
    end
    @(negedge clk);
  endtask

  task automatic test_branch_priority;
    sus1 = 1'b1; br1 = 1'b1; #1;
    n_checks++;
    if (o1 !== O_FLUSH) begin
      n_fail++; $display("FAIL br_over_sus: got %b want %b", o1, O_FLUSH);
    end
    @(negedge clk);
    sus1 = 1'b0; br1 = 1'b0; #1;
    n_checks++;
    if (o1 !== O_RUN) begin
      n_fail++; $display("FAIL br_next_run: got %b want %b", o1, O_RUN);
    end
    @(negedge clk);
    // Branch from STALL must clear the stall count so 1+3 stalls do not trip the watchdog.
    sus1 = 1'b1; #1;
    @(negedge clk);
    br1 = 1'b1; #1;
    n_checks++;
    if (o1 !== O_FLUSH) begin
      n_fail++; $display("FAIL br_in_stall: got %b want %b", o1, O_FLUSH);
    end
    @(negedge clk);
    br1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (o1 !== O_STALL) begin
        n_fail++; $display("FAIL br_cnt_clear cyc%0d: got %b want %b", i, o1, O_STALL);
      end
      @(negedge clk);
    end
    sus1 = 1'b0; #1;
    n_checks++;
    if (o1 !== O_RUN) begin
      n_fail++; $display("FAIL br_cnt_clear_end: got %b want %b", o1, O_RUN);
    end
    @(negedge clk);
  endtask

  task automatic test_flush3;
    logic [5:0] exp_a [4];
    logic [5:0] exp_b [5];
    exp_a = '{O_FLUSH, O_FLUSH, O_FLUSH, O_STALL};
    exp_b = '{O_FLUSH, O_FLUSH, O_FLUSH, O_FLUSH, O_RUN};
    // Branch then suspend: suspend is ignored for the two follow-on flush cycles.
    for (int i = 0; i < 4; i++) begin
      br2 = (i == 0); sus2 = (i != 0); #1;
      n_checks++;
      if (o2 !== exp_a[i]) begin
        n_fail++; $display("FAIL flush3_sus cyc%0d: got %b want %b", i + 1, o2, exp_a[i]);
      end
      @(negedge clk);
    end
    sus2 = 1'b0; br2 = 1'b0;
    @(negedge clk);
    // Second branch in cycle 2 restarts the flush window.
    for (int i = 0; i < 5; i++) begin
      br2 = (i < 2); #1;
      n_checks++;
      if (o2 !== exp_b[i]) begin
        n_fail++; $display("FAIL flush3_restart cyc%0d: got %b want %b", i + 1, o2, exp_b[i]);
      end
      @(negedge clk);
    end
    // Reset mid-flush returns straight to RUN after release.
    br2 = 1'b1; #1;
    @(negedge clk);
    br2 = 1'b0; rst_i = 1'b0; #1;
    @(negedge clk);
    rst_i = 1'b1; #1;
    n_checks++;
    if (o2 !== O_RUN) begin
      n_fail++; $display("FAIL flush3_reset_mid: got %b want %b", o2, O_RUN);
    end
    @(negedge clk);
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf;
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    sus1 = 1'b1;
    repeat (3) @(negedge clk);
    sus1 = 1'b0;
    @(negedge clk);
    sus1 = 1'b1; br1 = 1'b1;
    @(negedge clk);
    sus1 = 1'b0; br1 = 1'b0; #1;
    n_checks++;
    if (stall_cyc1 !== 32'd3 || flush_ev1 !== 32'd1) begin
      n_fail++; $display("FAIL perf_counts: got %0d/%0d want 3/1", stall_cyc1, flush_ev1);
    end
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    sus1 = 1'b1;
    @(negedge clk);
    sus1 = 1'b0; #1;
    n_checks++;
    if (stall_cyc1 !== 32'd0) begin
      n_fail++; $display("FAIL perf_wrap: got %h want 00000000", stall_cyc1);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stall3();
    test_watchdog();
    test_branch_priority();
    test_flush3();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
